// File: rtl/lenet_pkg.sv
// Shared LeNet constants and the conv-2 writeback state encoding.
package lenet_pkg;

  localparam int OUT_MAPS    = 16;
  localparam int OUT_PIX     = 100;
  localparam int ACC_W       = 32;
  localparam int DATA_W      = 16;
  localparam int FRAC_SHIFT  = 8;
  localparam int BIAS_BASE   = 4;
  localparam int OFM_ADDR_W  = 11;
  localparam int BIAS_ADDR_W = 7;

  localparam int MAP_W = $clog2(OUT_MAPS);
  localparam int PIX_W = $clog2(OUT_PIX);

  localparam logic [MAP_W-1:0] MAP_LAST = MAP_W'(OUT_MAPS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(OUT_PIX - 1);

  typedef enum logic [2:0] {
    WB_IDLE,
    WB_BIAS_REQ,
    WB_BIAS_WAIT,
    WB_RUN,
    WB_DRAIN,
    WB_DONE
  } wb_state_t;

endpackage

// File: rtl/relu_sat_q.sv
// Bias add at accumulator scale, then ReLU, rescale and saturate to storage width.
// The two halves are separate so a caller can register between them.
module relu_sat_q
  import lenet_pkg::*;
(
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [DATA_W-1:0] i_bias,
  output logic signed [ACC_W:0]    o_sum,
  input  logic signed [ACC_W:0]    i_sum,
  output logic signed [DATA_W-1:0] o_q
);

  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((2 ** (DATA_W-1)) - 1);

  logic signed [ACC_W:0] w_acc_x;
  logic signed [ACC_W:0] w_bias_x;
  logic signed [ACC_W:0] w_shr;

  always_comb begin
    w_acc_x  = {i_acc[ACC_W-1], i_acc};
    w_bias_x = {{(ACC_W+1-DATA_W){i_bias[DATA_W-1]}}, i_bias};
    o_sum    = w_acc_x + (w_bias_x <<< FRAC_SHIFT);
  end

  always_comb begin
    w_shr = i_sum >>> FRAC_SHIFT;
    if (i_sum < 0) begin
      o_q = '0;
    end else if (w_shr > Q_MAX) begin
      o_q = Q_MAX[DATA_W-1:0];
    end else begin
      o_q = w_shr[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/conv_2_writeback.sv
// Conv layer-2 writeback: per-map bias fetch, 2-stage bias/ReLU/saturate pipeline,
// output feature-map BRAM writes and completion handshake to the LeNet sequencer.
//
// state        | meaning
// WB_IDLE      | waiting for a rising edge on wb_en
// WB_BIAS_REQ  | bias BRAM read issued for the current map
// WB_BIAS_WAIT | bias word returning, latched at end of cycle
// WB_RUN       | accepting accumulator beats for the current map
// WB_DRAIN     | last beat accepted, waiting for the pipeline to empty
// WB_DONE      | wb_finish held until wb_en drops
module conv_2_writeback
  import lenet_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en,
  input  logic                   acc_valid,
  input  logic [ACC_W-1:0]       acc_data,
  output logic                   acc_ready,
  output logic                   bias_bram_en,
  output logic [BIAS_ADDR_W-1:0] bias_bram_addr,
  input  logic [DATA_W-1:0]      bias_bram_dout,
  output logic                   ofm_bram_en,
  output logic                   ofm_bram_we,
  output logic [OFM_ADDR_W-1:0]  ofm_bram_addr,
  output logic [DATA_W-1:0]      ofm_bram_din,
  output logic                   wb_finish
);

  wb_state_t              r_state;
  logic                   r_wb_en_d;
  logic [MAP_W-1:0]       r_map;
  logic [PIX_W-1:0]       r_pix;
  logic [DATA_W-1:0]      r_bias;
  logic                   r_acc_ready;
  logic                   r_bias_en;
  logic [BIAS_ADDR_W-1:0] r_bias_addr;
  logic                   r_s1_valid;
  logic signed [ACC_W:0]  r_s1_sum;
  logic [MAP_W-1:0]       r_s1_map;
  logic [PIX_W-1:0]       r_s1_pix;
  logic                   r_ofm_en;
  logic [OFM_ADDR_W-1:0]  r_ofm_addr;
  logic [DATA_W-1:0]      r_ofm_din;
  logic                   r_finish;

  logic                   w_wb_en_p;
  logic                   w_accept;
  logic signed [ACC_W:0]  w_sum;
  logic signed [DATA_W-1:0] w_q;
  logic [OFM_ADDR_W-1:0]  w_ofm_addr;
  logic [MAP_W-1:0]       w_map_next;

  assign w_wb_en_p  = wb_en & ~r_wb_en_d;
  assign w_accept   = acc_valid & r_acc_ready;
  assign w_map_next = r_map + MAP_W'(1);
  assign w_ofm_addr = OFM_ADDR_W'(r_s1_map) * OFM_ADDR_W'(OUT_PIX) + OFM_ADDR_W'(r_s1_pix);

  relu_sat_q u_relu_sat_q (
    .i_acc  (acc_data),
    .i_bias (r_bias),
    .o_sum  (w_sum),
    .i_sum  (r_s1_sum),
    .o_q    (w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WB_IDLE;
      r_wb_en_d   <= 1'b0;
      r_map       <= '0;
      r_pix       <= '0;
      r_bias      <= '0;
      r_acc_ready <= 1'b0;
      r_bias_en   <= 1'b0;
      r_bias_addr <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_map    <= '0;
      r_s1_pix    <= '0;
      r_ofm_en    <= 1'b0;
      r_ofm_addr  <= '0;
      r_ofm_din   <= '0;
      r_finish    <= 1'b0;
    end else begin
      r_wb_en_d   <= wb_en;
      r_bias_en   <= 1'b0;
      r_bias_addr <= '0;

      // Tags ride with each beat so a map switch cannot disturb in-flight data.
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sum <= w_sum;
        r_s1_map <= r_map;
        r_s1_pix <= r_pix;
      end
      r_ofm_en   <= r_s1_valid;
      r_ofm_addr <= r_s1_valid ? w_ofm_addr : '0;
      r_ofm_din  <= r_s1_valid ? w_q : '0;

      if ((r_state != WB_IDLE) && !wb_en) begin
        r_state     <= WB_IDLE;
        r_map       <= '0;
        r_pix       <= '0;
        r_acc_ready <= 1'b0;
        r_s1_valid  <= 1'b0;
        r_ofm_en    <= 1'b0;
        r_ofm_addr  <= '0;
        r_ofm_din   <= '0;
        r_finish    <= 1'b0;
      end else begin
        case (r_state)
          WB_IDLE: begin
            if (w_wb_en_p) begin
              r_state     <= WB_BIAS_REQ;
              r_map       <= '0;
              r_pix       <= '0;
              r_bias_en   <= 1'b1;
              r_bias_addr <= BIAS_ADDR_W'(BIAS_BASE);
            end
          end
          WB_BIAS_REQ: begin
            r_state <= WB_BIAS_WAIT;
          end
          WB_BIAS_WAIT: begin
            r_bias      <= bias_bram_dout;
            r_state     <= WB_RUN;
            r_acc_ready <= 1'b1;
          end
          WB_RUN: begin
            if (w_accept) begin
              if (r_pix == PIX_LAST) begin
                r_pix       <= '0;
                r_acc_ready <= 1'b0;
                if (r_map == MAP_LAST) begin
                  r_state <= WB_DRAIN;
                end else begin
                  r_map       <= w_map_next;
                  r_state     <= WB_BIAS_REQ;
                  r_bias_en   <= 1'b1;
                  r_bias_addr <= BIAS_ADDR_W'(BIAS_BASE) + BIAS_ADDR_W'(w_map_next);
                end
              end else begin
                r_pix <= r_pix + PIX_W'(1);
              end
            end
          end
          WB_DRAIN: begin
            if (!r_s1_valid && !r_ofm_en) begin
              r_state  <= WB_DONE;
              r_finish <= 1'b1;
            end
          end
          WB_DONE: begin
            r_finish <= 1'b1;
          end
          default: begin
            r_state <= WB_IDLE;
          end
        endcase
      end
    end
  end

  assign acc_ready      = r_acc_ready;
  assign bias_bram_en   = r_bias_en;
  assign bias_bram_addr = r_bias_addr;
  assign ofm_bram_en    = r_ofm_en;
  assign ofm_bram_we    = r_ofm_en;
  assign ofm_bram_addr  = r_ofm_addr;
  assign ofm_bram_din   = r_ofm_din;
  assign wb_finish      = r_finish;

endmodule
